// File: rtl/apb_seq_booth_mac.sv
// rtl/apb_seq_booth_mac.sv - APB4 slave wrapping a sequential radix-2 Booth multiply-accumulate engine
//
// Optional feature macro: BOOTH_MAC_IRQ_EN (adds IRQ_EN register at 0x18 and the IRQ port)
//
// Ports:
//   S_PCLK     in   clock, all logic on rising edge
//   S_PRESETN  in   asynchronous active-low reset
//   S_PADDR    in   APB address, only [4:2] decoded
//   S_PSEL     in   APB select
//   S_PENABLE  in   APB access phase
//   S_PWRITE   in   1 = write, 0 = read
//   S_PWDATA   in   APB write data
//   S_PREADY   out  S_PSEL & S_PENABLE, zero wait states
//   S_PRDATA   out  read data in access phase, 0 otherwise
//   S_PSLVERR  out  unmapped access or operand/control write while busy
//   IRQ        out  registered DONE & IRQ_EN[0] (BOOTH_MAC_IRQ_EN only)
//
// Register map (word index = S_PADDR[4:2]):
//   0 OPA, 1 OPB, 2 CTRL {CLR_ACC, ACC, SIGNED, START}, 3 STAT {OVF, DONE, BUSY},
//   4 RES_LO, 5 RES_HI, 6 IRQ_EN (macro only), 7 unmapped
module apb_seq_booth_mac #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH   = 16
) (
    input  logic                  S_PCLK,
    input  logic                  S_PRESETN,
    input  logic [ADDR_WIDTH-1:0] S_PADDR,
    input  logic                  S_PSEL,
    input  logic                  S_PENABLE,
    input  logic                  S_PWRITE,
    input  logic [DATA_WIDTH-1:0] S_PWDATA,
    output logic                  S_PREADY,
    output logic [DATA_WIDTH-1:0] S_PRDATA,
    output logic                  S_PSLVERR
`ifdef BOOTH_MAC_IRQ_EN
    ,
    output logic                  IRQ
`endif
);

    localparam int W  = OP_WIDTH;
    localparam int RW = 2 * OP_WIDTH;
    localparam int CW = $clog2(OP_WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    state_t          state;
    logic [W-1:0]    opa_r;
    logic [W-1:0]    opb_r;
    logic            sgn_r;
    logic            acc_r;
    logic            sgn_l;
    logic            acc_l;
    logic            done_r;
    logic            ovf_r;
    logic [RW-1:0]   res_r;
    // Booth datapath: A carries one guard bit beyond the W+1-bit operands so that
    // subtracting a most-negative multiplicand cannot wrap.
    logic [W+1:0]    m_r;
    logic [W+1:0]    a_r;
    logic [W:0]      q_r;
    logic            qm1_r;
    logic [CW-1:0]   cnt_r;

    logic            access;
    logic [2:0]      idx;
    logic            busy;
    logic            unmapped;
    logic            err;
    logic            wr;
    logic            start;
    logic            clr_acc;
    logic            done_clr;
    logic            ovf_clr;
    logic [W+1:0]    a_sum;
    logic [2*W+2:0]  full;
    logic [RW-1:0]   prod;
    logic [RW:0]     add;
    logic            sovf;
    logic [63:0]     res_ext;
    logic [31:0]     rd;

    assign access   = S_PSEL & S_PENABLE;
    assign idx      = S_PADDR[4:2];
    assign busy     = (state != IDLE);
`ifdef BOOTH_MAC_IRQ_EN
    assign unmapped = (idx == 3'd7);
`else
    assign unmapped = (idx == 3'd7) | (idx == 3'd6);
`endif
    assign err      = unmapped | (S_PWRITE & busy & (idx <= 3'd2));
    assign wr       = access & S_PWRITE & ~err;
    assign start    = wr & (idx == 3'd2) & S_PWDATA[0];
    assign clr_acc  = wr & (idx == 3'd2) & S_PWDATA[3];
    assign done_clr = wr & (idx == 3'd3) & S_PWDATA[1];
    assign ovf_clr  = wr & (idx == 3'd3) & S_PWDATA[2];

    assign S_PREADY  = access;
    assign S_PSLVERR = access & err;
    assign S_PRDATA  = (access & ~err) ? rd : '0;

    always_comb begin
        case ({q_r[0], qm1_r})
            2'b01:   a_sum = a_r + m_r;
            2'b10:   a_sum = a_r - m_r;
            default: a_sum = a_r;
        endcase
    end

    assign full    = {a_r, q_r};
    assign prod    = full[RW-1:0];
    assign add     = {1'b0, res_r} + {1'b0, prod};
    assign sovf    = (res_r[RW-1] == prod[RW-1]) & (add[RW-1] != res_r[RW-1]);
    assign res_ext = 64'(res_r);

`ifdef BOOTH_MAC_IRQ_EN
    logic irq_en_r;
    logic irq_r;
    logic done_nxt;
    logic irq_en_nxt;
    assign done_nxt   = (state == FIN) | (done_r & ~done_clr);
    assign irq_en_nxt = (wr & (idx == 3'd6)) ? S_PWDATA[0] : irq_en_r;
    assign IRQ        = irq_r;
`endif

    always_comb begin
        rd = '0;
        case (idx)
            3'd0: rd = 32'(opa_r);
            3'd1: rd = 32'(opb_r);
            3'd2: rd = {29'd0, acc_r, sgn_r, 1'b0};
            3'd3: rd = {29'd0, ovf_r, done_r, busy};
            3'd4: rd = res_ext[31:0];
            3'd5: rd = res_ext[63:32];
`ifdef BOOTH_MAC_IRQ_EN
            3'd6: rd = {31'd0, irq_en_r};
`endif
            default: rd = '0;
        endcase
    end

    wire unused_bits = ^{S_PADDR, S_PWDATA, full[2*W+2:RW]};

    always_ff @(posedge S_PCLK or negedge S_PRESETN) begin
        if (!S_PRESETN) begin
            state  <= IDLE;
            opa_r  <= '0;
            opb_r  <= '0;
            sgn_r  <= 1'b0;
            acc_r  <= 1'b0;
            sgn_l  <= 1'b0;
            acc_l  <= 1'b0;
            done_r <= 1'b0;
            ovf_r  <= 1'b0;
            res_r  <= '0;
            m_r    <= '0;
            a_r    <= '0;
            q_r    <= '0;
            qm1_r  <= 1'b0;
            cnt_r  <= '0;
`ifdef BOOTH_MAC_IRQ_EN
            irq_en_r <= 1'b0;
            irq_r    <= 1'b0;
`endif
        end else begin
            if (wr) begin
                case (idx)
                    3'd0: opa_r <= S_PWDATA[W-1:0];
                    3'd1: opb_r <= S_PWDATA[W-1:0];
                    3'd2: begin
                        sgn_r <= S_PWDATA[1];
                        acc_r <= S_PWDATA[2];
                    end
`ifdef BOOTH_MAC_IRQ_EN
                    3'd6: irq_en_r <= S_PWDATA[0];
`endif
                    default: ;
                endcase
            end
            if (done_clr) done_r <= 1'b0;
            if (ovf_clr)  ovf_r  <= 1'b0;
            if (clr_acc)  res_r  <= '0;

            case (state)
                IDLE: begin
                    if (start) begin
                        // Operands extended to W+1 bits (plus A's guard bit) per SIGNED.
                        m_r   <= {{2{S_PWDATA[1] & opa_r[W-1]}}, opa_r};
                        q_r   <= {S_PWDATA[1] & opb_r[W-1], opb_r};
                        a_r   <= '0;
                        qm1_r <= 1'b0;
                        cnt_r <= '0;
                        sgn_l <= S_PWDATA[1];
                        acc_l <= S_PWDATA[2];
                        state <= CALC;
                    end
                end
                CALC: begin
                    // Arithmetic shift right of {A, Q, q-1} after the add/subtract.
                    a_r   <= {a_sum[W+1], a_sum[W+1:1]};
                    q_r   <= {a_sum[0], q_r[W:1]};
                    qm1_r <= q_r[0];
                    cnt_r <= cnt_r + 1'b1;
                    if (cnt_r == CW'(W)) state <= FIN;
                end
                FIN: begin
                    res_r  <= acc_l ? add[RW-1:0] : prod;
                    done_r <= 1'b1;
                    if (acc_l & (sgn_l ? sovf : add[RW])) ovf_r <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
`ifdef BOOTH_MAC_IRQ_EN
            irq_r <= done_nxt & irq_en_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_apb_seq_booth_mac.sv
// tb/tb_apb_seq_booth_mac.sv - self-checking bench for apb_seq_booth_mac with behavioural model
module tb_apb_seq_booth_mac;

    localparam int W = 16;
    localparam longint MASK = (64'sd1 <<< (2 * W)) - 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  paddr = '0;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [31:0] pwdata = '0;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;
`ifdef BOOTH_MAC_IRQ_EN
    logic        irq;
`endif

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    apb_seq_booth_mac #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .OP_WIDTH(W)) dut (
        .S_PCLK    (clk),
        .S_PRESETN (rst_n),
        .S_PADDR   (paddr),
        .S_PSEL    (psel),
        .S_PENABLE (penable),
        .S_PWRITE  (pwrite),
        .S_PWDATA  (pwdata),
        .S_PREADY  (pready),
        .S_PRDATA  (prdata),
        .S_PSLVERR (pslverr)
`ifdef BOOTH_MAC_IRQ_EN
        ,
        .IRQ       (irq)
`endif
    );

    // Behavioural model state
    logic [W-1:0] m_opa, m_opb, l_opa, l_opb;
    bit           m_sgn, m_acc, l_sgn, l_acc, m_done, m_ovf, m_irq_en, m_irq;
    longint       m_res;
    int           m_busy;

    function automatic longint sx(input longint v, input int bits);
        longint h;
        h = 64'sd1 <<< (bits - 1);
        return (v ^ h) - h;
    endfunction

    function automatic longint product(input logic [W-1:0] a, input logic [W-1:0] b, input bit s);
        longint x, y;
        x = s ? sx(longint'(a), W) : longint'(a);
        y = s ? sx(longint'(b), W) : longint'(b);
        return (x * y) & MASK;
    endfunction

    function automatic bit m_err(input logic [7:0] a, input bit w);
        logic [2:0] i;
        bit unm;
        i = a[4:2];
`ifdef BOOTH_MAC_IRQ_EN
        unm = (i == 3'd7);
`else
        unm = (i == 3'd7) || (i == 3'd6);
`endif
        return unm || (w && m_busy > 0 && i <= 3'd2);
    endfunction

    function automatic logic [31:0] m_rd(input logic [2:0] i);
        case (i)
            3'd0: return 32'(m_opa);
            3'd1: return 32'(m_opb);
            3'd2: return {29'd0, m_acc, m_sgn, 1'b0};
            3'd3: return {29'd0, m_ovf, m_done, m_busy > 0};
            3'd4: return m_res[31:0];
            3'd5: return 32'(m_res >>> 32);
            3'd6: return {31'd0, m_irq_en};
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update at each active edge, from the bus values in flight.
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_opa = '0; m_opb = '0; l_opa = '0; l_opb = '0;
            m_sgn = 0; m_acc = 0; l_sgn = 0; l_acc = 0;
            m_done = 0; m_ovf = 0; m_irq_en = 0; m_irq = 0;
            m_res = 0; m_busy = 0;
        end else begin
            bit e, fin;
            longint p, s, h;
            e = m_err(paddr, pwrite);
            fin = 0;
            if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0) fin = 1;
            end
            if (psel && penable && pwrite && !e) begin
                case (paddr[4:2])
                    3'd0: m_opa = pwdata[W-1:0];
                    3'd1: m_opb = pwdata[W-1:0];
                    3'd2: begin
                        m_sgn = pwdata[1];
                        m_acc = pwdata[2];
                        if (pwdata[3]) m_res = 0;
                        if (pwdata[0]) begin
                            l_opa = m_opa; l_opb = m_opb;
                            l_sgn = pwdata[1]; l_acc = pwdata[2];
                            m_busy = W + 2;
                        end
                    end
                    3'd3: begin
                        if (pwdata[1]) m_done = 0;
                        if (pwdata[2]) m_ovf = 0;
                    end
                    3'd6: m_irq_en = pwdata[0];
                    default: ;
                endcase
            end
            if (fin) begin
                p = product(l_opa, l_opb, l_sgn);
                if (l_acc) begin
                    if (l_sgn) begin
                        h = 64'sd1 <<< (2 * W - 1);
                        s = sx(m_res, 2 * W) + sx(p, 2 * W);
                        if (s >= h || s < -h) m_ovf = 1;
                    end else if (m_res + p > MASK) begin
                        m_ovf = 1;
                    end
                    m_res = (m_res + p) & MASK;
                end else begin
                    m_res = p;
                end
                m_done = 1;
            end
            m_irq = m_done && m_irq_en;
        end
    end

    // Output compare against the model, away from the active edge.
    initial forever begin
        @(negedge clk);
        chk("pready", pready, psel && penable);
        if (rst_n && psel && penable) begin
            bit e;
            e = m_err(paddr, pwrite);
            chk("pslverr", pslverr, e);
            if (!pwrite) chk("prdata", prdata, e ? 32'd0 : m_rd(paddr[4:2]));
        end else begin
            chk("prdata idle", prdata, 0);
            chk("pslverr idle", pslverr, 0);
        end
`ifdef BOOTH_MAC_IRQ_EN
        chk("irq", irq, m_irq);
`endif
    end

    task automatic apb(input bit w, input logic [7:0] a, input logic [31:0] d,
                       output logic [31:0] r, output logic e);
        @(posedge clk); #1;
        psel = 1; penable = 0; pwrite = w; paddr = a; pwdata = d;
        @(posedge clk); #1;
        penable = 1;
        @(negedge clk);
        r = prdata; e = pslverr;
        @(posedge clk); #1;
        psel = 0; penable = 0; pwrite = 0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        logic [31:0] r; logic e;
        apb(1, a, d, r, e);
    endtask

    task automatic rdr(input logic [7:0] a, output logic [31:0] r);
        logic e;
        apb(0, a, 0, r, e);
    endtask

    task automatic wait_idle();
        logic [31:0] r;
        r = 32'd1;
        for (int k = 0; k < 30 && r[0]; k++) rdr(8'h0C, r);
        chk("wait_idle busy", r[0], 0);
    endtask

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 5))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h8000;
            3: return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] r;
        logic e;
        repeat (3) @(posedge clk);
        #3 rst_n = 1;

        for (int i = 0; i < 6; i++) begin
            apb(0, 8'(i * 4), 0, r, e);
            chk("reset reg", r, 0);
            chk("reset err", e, 0);
        end

        // Unsigned all-ones squared; BUSY still set 17 edges after START
        wr(8'h00, 32'hFFFF); wr(8'h04, 32'hFFFF); wr(8'h08, 32'h1);
        repeat (15) @(posedge clk);
        rdr(8'h0C, r); chk("busy late", r[0], 1);
        wait_idle();
        rdr(8'h10, r); chk("ffff^2 lo", r, 32'hFFFE0001);
        rdr(8'h14, r); chk("ffff^2 hi", r, 0);
        rdr(8'h0C, r); chk("stat done", r, 32'h2);

        // BUSY gone and DONE set exactly 18 edges after START; old RES held while busy
        wr(8'h0C, 32'h2);
        rdr(8'h0C, r); chk("done w1c", r, 0);
        wr(8'h00, 32'h3); wr(8'h04, 32'h5); wr(8'h08, 32'h1);
        rdr(8'h10, r); chk("res held", r, 32'hFFFE0001);
        repeat (13) @(posedge clk);
        rdr(8'h0C, r); chk("stat at 18", r, 32'h2);
        rdr(8'h11, r); chk("3*5 low addr bits", r, 32'd15);

        // Signed edge cases
        wr(8'h00, 32'h8000); wr(8'h04, 32'h8000); wr(8'h08, 32'h3);
        wait_idle();
        rdr(8'h10, r); chk("min*min", r, 32'h40000000);
        rdr(8'h0C, r); chk("min*min stat", r, 32'h2);
        wr(8'h00, 32'hFFFD); wr(8'h04, 32'h0007); wr(8'h08, 32'h3);
        wait_idle();
        rdr(8'h10, r); chk("-3*7", r, 32'hFFFFFFEB);

        // Signed accumulate chain
        wr(8'h00, 32'h7FFF); wr(8'h04, 32'h7FFF); wr(8'h08, 32'hB);
        wait_idle(); rdr(8'h10, r); chk("acc1", r, 32'h3FFF0001);
        wr(8'h08, 32'h7);
        wait_idle(); rdr(8'h10, r); chk("acc2", r, 32'h7FFE0002);
        wr(8'h00, 32'h8000); wr(8'h08, 32'h7);
        wait_idle(); rdr(8'h10, r); chk("acc3", r, 32'h3FFE8002);
        rdr(8'h0C, r); chk("acc3 no ovf", r, 32'h2);
        wr(8'h00, 32'h7FFF); wr(8'h08, 32'h7);
        wait_idle(); rdr(8'h10, r); chk("acc4", r, 32'h7FFD8003);
        wr(8'h08, 32'h7);
        wait_idle(); rdr(8'h10, r); chk("acc5", r, 32'hBFFC8004);
        rdr(8'h0C, r); chk("acc5 ovf", r, 32'h6);
        wr(8'h0C, 32'h6);
        rdr(8'h0C, r); chk("ovf w1c", r, 0);

        // Protocol errors
        wr(8'h00, 32'h3); wr(8'h04, 32'h5); wr(8'h08, 32'h9);
        apb(1, 8'h00, 32'h100, r, e); chk("opa busy err", e, 1);
        wait_idle();
        rdr(8'h00, r); chk("opa kept", r, 32'h3);
        rdr(8'h10, r); chk("res orig opa", r, 32'd15);
        apb(0, 8'h1C, 0, r, e); chk("0x1c err", e, 1); chk("0x1c data", r, 0);
`ifndef BOOTH_MAC_IRQ_EN
        apb(1, 8'h18, 32'h1, r, e); chk("0x18 err", e, 1);
`endif

        // Reset during CALC
        wr(8'h00, 32'hFFFF); wr(8'h04, 32'hFFFF); wr(8'h08, 32'h1);
        repeat (5) @(posedge clk);
        #3 rst_n = 0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1;
        rdr(8'h0C, r); chk("stat after rst", r, 0);
        rdr(8'h10, r); chk("res after rst", r, 0);
        repeat (20) @(posedge clk);
        rdr(8'h0C, r); chk("no late done", r, 0);
        wr(8'h00, 32'h3); wr(8'h04, 32'h5); wr(8'h08, 32'h1);
        wait_idle();
        rdr(8'h10, r); chk("post rst op", r, 32'd15);

        // Randomized operations against the model
        for (int it = 0; it < 60; it++) begin
            logic [15:0] a, b;
            logic [3:0] c;
            a = pick(); b = pick(); c = 4'($urandom_range(0, 15));
            wr(8'h00, 32'(a)); wr(8'h04, 32'(b)); wr(8'h08, 32'(c));
            if ($urandom_range(0, 2) == 0) wr(8'h00, $urandom);
            if ($urandom_range(0, 3) == 0) rdr(8'h10, r);
            if ($urandom_range(0, 3) == 0) wr(8'h0C, 32'($urandom_range(0, 7)));
            if ($urandom_range(0, 4) == 0) rdr(8'($urandom_range(0, 31)), r);
            repeat ($urandom_range(0, 4)) @(posedge clk);
            wait_idle();
            rdr(8'h10, r);
            rdr(8'h14, r);
            rdr(8'h0C, r);
            rdr(8'h08, r);
            if ($urandom_range(0, 3) == 0) wr(8'h0C, 32'h6);
        end

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
